// File: rtl/contador_modular_pkg.sv
// Shared constants and helpers for the modular counter family.
package contador_pkg;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Load values above the terminal value are pinned to it so count never leaves 0..max.
  function automatic logic [31:0] clamp(input logic [31:0] val, input logic [31:0] max);
    return (val > max) ? max : val;
  endfunction

endpackage

// File: rtl/contador_prescaler.sv
// Enable-gated prescaler: tick fires on every PRESCALE-th enabled clock.
// PRESCALE=1 collapses to tick=en with no state.
module contador_prescaler #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  generate
    if (PRESCALE <= 1) begin : g_bypass
      logic presc_unused;
      assign presc_unused = ^{clk, rst_n, clr};
      assign tick = en;
    end else begin : g_div
      localparam int unsigned PW = $clog2(PRESCALE);
      localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);
      localparam logic [PW-1:0] PONE = PW'(1);

      logic [PW-1:0] presc;

      assign tick = en && (presc == PMAX);

      // Phase is kept across en deassertion; only reset and load restart it.
      always_ff @(posedge clk) begin
        if (!rst_n)      presc <= '0;
        else if (clr)    presc <= '0;
        else if (en)     presc <= (presc == PMAX) ? '0 : presc + PONE;
      end
    end
  endgenerate

endmodule

// File: rtl/contador_modular.sv
// Up/down modulo-(MAX_VAL+1) counter with load, prescaler and terminal-count pulse.
// Define CONTADOR_MODULAR_SAT_EN to saturate at 0/MAX_VAL instead of wrapping.
module contador_modular
  import contador_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter logic [31:0] MAX_VAL  = 32'd65535,
  parameter int unsigned PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic             tick;
  logic [WIDTH-1:0] load_cnt;
  logic [WIDTH-1:0] step_cnt;
  logic             step_tc;

  contador_prescaler #(.PRESCALE(PRESCALE)) u_presc (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .clr  (load),
    .tick (tick)
  );

  assign load_cnt = WIDTH'(clamp(32'(load_val), MAX_VAL));

  always_comb begin
    step_cnt = count;
    step_tc  = 1'b0;
    case (up_dn)
      DIR_UP: begin
`ifdef CONTADOR_MODULAR_SAT_EN
        if (count != MAXV) begin
          step_cnt = count + ONE;
          step_tc  = (count == MAXV - ONE);
        end
`else
        if (count == MAXV) begin
          step_cnt = '0;
          step_tc  = 1'b1;
        end else begin
          step_cnt = count + ONE;
        end
`endif
      end
      DIR_DN: begin
`ifdef CONTADOR_MODULAR_SAT_EN
        if (count != '0) begin
          step_cnt = count - ONE;
          step_tc  = (count == ONE);
        end
`else
        if (count == '0) begin
          step_cnt = MAXV;
          step_tc  = 1'b1;
        end else begin
          step_cnt = count - ONE;
        end
`endif
      end
    endcase
  end

  // tc is registered alongside count so it lines up with the wrapped value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
      tc    <= 1'b0;
    end else if (load) begin
      count <= load_cnt;
      tc    <= 1'b0;
    end else if (tick) begin
      count <= step_cnt;
      tc    <= step_tc;
    end else begin
      tc    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_contador_modular.sv
// Bench for contador_modular: two instances (PRESCALE 1 and 4, MAX_VAL 9) against a behavioural model.
module tb_contador_modular;

  localparam int MAXM = 9;
  localparam int PA   = 1;
  localparam int PB   = 4;

  logic       clk = 1'b0;
  logic       rst_n, en, up, load;
  logic [3:0] lv;
  logic [3:0] ca, cb;
  logic       tca, tcb;

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  int m_cnt[2];
  int m_tc[2];
  int m_ps[2];

  always #5 clk = ~clk;

  contador_modular #(.WIDTH(4), .MAX_VAL(32'd9), .PRESCALE(PA)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up), .load(load), .load_val(lv),
    .count(ca), .tc(tca)
  );

  contador_modular #(.WIDTH(4), .MAX_VAL(32'd9), .PRESCALE(PB)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up), .load(load), .load_val(lv),
    .count(cb), .tc(tcb)
  );

  // Reference: count as an integer in 0..MAXM, prescaler as a plain modulo phase.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int p;
      bit tk;
      p = (k == 0) ? PA : PB;
      if (!rst_n) begin
        m_cnt[k] = 0; m_tc[k] = 0; m_ps[k] = 0;
      end else if (load) begin
        m_cnt[k] = (int'(lv) > MAXM) ? MAXM : int'(lv);
        m_tc[k]  = 0; m_ps[k] = 0;
      end else if (en) begin
        tk = (m_ps[k] == p - 1);
        m_ps[k] = (m_ps[k] + 1) % p;
        m_tc[k] = 0;
        if (tk) begin
`ifdef CONTADOR_MODULAR_SAT_EN
          if (up && m_cnt[k] < MAXM) begin
            m_cnt[k] = m_cnt[k] + 1; m_tc[k] = (m_cnt[k] == MAXM);
          end else if (!up && m_cnt[k] > 0) begin
            m_cnt[k] = m_cnt[k] - 1; m_tc[k] = (m_cnt[k] == 0);
          end
`else
          if (up) begin
            m_tc[k] = (m_cnt[k] == MAXM); m_cnt[k] = (m_cnt[k] + 1) % (MAXM + 1);
          end else begin
            m_tc[k] = (m_cnt[k] == 0); m_cnt[k] = (m_cnt[k] + MAXM) % (MAXM + 1);
          end
`endif
        end
      end else begin
        m_tc[k] = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      checks += 4;
      if (int'(ca) != m_cnt[0]) begin errors++; $display("FAIL cnt_a: got %0d expected %0d t=%0t", ca, m_cnt[0], $time); end
      if (int'(tca) != m_tc[0]) begin errors++; $display("FAIL tc_a: got %0d expected %0d t=%0t", tca, m_tc[0], $time); end
      if (int'(cb) != m_cnt[1]) begin errors++; $display("FAIL cnt_b: got %0d expected %0d t=%0t", cb, m_cnt[1], $time); end
      if (int'(tcb) != m_tc[1]) begin errors++; $display("FAIL tc_b: got %0d expected %0d t=%0t", tcb, m_tc[1], $time); end
    end
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic lit(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d t=%0t", name, act, exp, $time);
    end
  endtask

  initial begin
    int e, t;
    rst_n = 1'b0; en = 1'b1; up = 1'b1; load = 1'b0; lv = 4'd0;

    // Reset held with en=1
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk_on = 1'b1;
      lit("rst_cnt", int'(ca), 0);
      lit("rst_tc", int'(tca), 0);
    end
    rst_n = 1'b1;
    cyc();
    lit("release_cnt", int'(ca), 1);

    // Up sequence from 0
    load = 1'b1; lv = 4'd0;
    cyc();
    lit("up_load", int'(ca), 0);
    load = 1'b0;
    for (int i = 1; i <= 11; i++) begin
      cyc();
`ifdef CONTADOR_MODULAR_SAT_EN
      e = (i < 9) ? i : 9;  t = (i == 9);
`else
      e = i % 10;           t = (i == 10);
`endif
      lit("up_cnt", int'(ca), e);
      lit("up_tc", int'(tca), t);
    end

    // Down sequence from 2
    load = 1'b1; lv = 4'd2; up = 1'b0;
    cyc();
    lit("dn_load", int'(ca), 2);
    load = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      cyc();
`ifdef CONTADOR_MODULAR_SAT_EN
      e = (i < 2) ? 2 - i : 0;  t = (i == 2);
`else
      e = (12 - i) % 10;         t = (i == 3);
`endif
      lit("dn_cnt", int'(ca), e);
      lit("dn_tc", int'(tca), t);
    end

    // Clamped load
    load = 1'b1; lv = 4'd15;
    cyc();
    lit("clamp_cnt", int'(ca), 9);
    lit("clamp_tc", int'(tca), 0);

    // Priority: reset beats load, then load beats step
    rst_n = 1'b0; load = 1'b1; en = 1'b1; lv = 4'd5;
    cyc();
    lit("prio_rst_a", int'(ca), 0);
    lit("prio_rst_b", int'(cb), 0);
    rst_n = 1'b1; lv = 4'd7; up = 1'b1;
    cyc();
    lit("prio_load", int'(ca), 7);

    // Prescaler divide and freeze
    lv = 4'd0;
    cyc();
    load = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      cyc();
      lit("presc_cnt", int'(cb), i / 4);
    end
    cyc(); cyc();
    lit("presc_mid", int'(cb), 4);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      lit("freeze_b", int'(cb), 4);
    end
    en = 1'b1;
    cyc();
    lit("resume_b0", int'(cb), 4);
    cyc();
    lit("resume_b1", int'(cb), 5);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 99) >= 2);
      load  = ($urandom_range(0, 99) < 5);
      en    = ($urandom_range(0, 99) < 80);
      up    = $urandom_range(0, 1) != 0;
      lv    = 4'($urandom_range(0, 15));
      cyc();
    end

    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
